regfile_scanner: RTL

Read-side companion to the core register file: on a start pulse it walks a contiguous range of architectural registers through one register-file read port and streams each value out with its index over a valid/ready handshake. It sits beside the register file, borrowing one read address/data pair. It feeds the debug/trace path that dumps register state, for example t1–t5 checks after a test program.

---
 rtl/regscan_pkg.sv | 15 +
 rtl/regfile_scanner.sv | 125 ++++++++++++
 2 files changed

// File: rtl/regscan_pkg.sv
// Shared constants and state encoding for the register-file scanner.
package regscan_pkg;

    localparam int REG_COUNT = 32;
    localparam int REG_AW    = 5;
    localparam int REG_DW    = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        SEND  = 2'd2,
        DONE  = 2'd3
    } state_e;

endpackage

// File: rtl/regfile_scanner.sv
// Walks registers FIRST_REG..LAST_REG through one register-file read port and
// streams each value with its index over a valid/ready handshake.
module regfile_scanner
    import regscan_pkg::*;
#(
    parameter int FIRST_REG = 0,
    parameter int LAST_REG  = 31
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic [REG_AW-1:0] ra,
    input  logic [REG_DW-1:0] rd,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_AW-1:0] out_idx,
    output logic [REG_DW-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    if (FIRST_REG < 0 || FIRST_REG > LAST_REG || LAST_REG >= REG_COUNT) begin : g_param_check
        $error("regfile_scanner: require 0 <= FIRST_REG <= LAST_REG < %0d", REG_COUNT);
    end

    localparam logic [REG_AW-1:0] FIRST_IDX = REG_AW'(FIRST_REG);
    localparam logic [REG_AW-1:0] LAST_IDX  = REG_AW'(LAST_REG);

    state_e              state_q, state_d;
    logic [REG_AW-1:0]   idx_q, idx_d;
    logic                out_valid_q, out_valid_d;
    logic [REG_AW-1:0]   out_idx_q, out_idx_d;
    logic [REG_DW-1:0]   out_data_q, out_data_d;
    logic                out_last_q, out_last_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        out_valid_d = out_valid_q;
        out_idx_d   = out_idx_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = FETCH;
                    idx_d   = FIRST_IDX;
                end
            end
            FETCH: begin
                out_data_d  = rd;
                out_idx_d   = idx_q;
                out_last_d  = (idx_q == LAST_IDX);
                out_valid_d = 1'b1;
                state_d     = SEND;
            end
            SEND: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    if (out_last_q) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 1'b1;
                        state_d = FETCH;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase

        // Abort overrides everything, including a same-cycle handshake or start.
        if (abort) begin
            state_d     = IDLE;
            idx_d       = '0;
            out_valid_d = 1'b0;
        end

        busy_d = (state_d != IDLE);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            out_valid_q <= out_valid_d;
            out_idx_q   <= out_idx_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    // idx is cleared on every return to IDLE, so it doubles as the read address.
    assign ra        = idx_q;
    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule
